acv_check_unit: RTL and testbench

Parametrised successor to the single-channel access-violation checker. Arbitrates protection checks from NCH requesters, such as I-stream prefetch and D-stream. For each accepted request it fetches the page's protection code over a PTE handshake. Accesses that cross a page boundary are checked internally as two sequential page lookups, not raised as a microtrap. Results are returned through a registered valid/ready response port.

---
 rtl/acv_pkg.sv | 40 ++++
 rtl/acv_check_unit_if.sv | 63 ++++++
 rtl/acv_rr_arb.sv | 46 ++++
 rtl/acv_check_unit.sv | 167 ++++++++++++++++
 tb/tb_acv_check_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/acv_pkg.sv
// Shared types, encodings and protection helpers for the access-violation checker.
package acv_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_WORD = 2'd1;
  localparam logic [1:0] SIZE_LONG = 2'd2;
  localparam logic [1:0] SIZE_QUAD = 2'd3;

  localparam logic [1:0] MODE_KERNEL = 2'd0;
  localparam logic [1:0] MODE_EXEC   = 2'd1;
  localparam logic [1:0] MODE_SUPER  = 2'd2;
  localparam logic [1:0] MODE_USER   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOOK1 = 2'd1,
    ST_LOOK2 = 2'd2,
    ST_RESP  = 2'd3
  } acv_state_e;

  typedef struct packed {
    logic acv;
    logic tnv;
    logic xpage;
    logic fpage;
  } acv_flags_t;

  // prot[3:2] is the read limit, prot[1:0] the write limit; a write limit also grants read.
  function automatic logic prot_ok(input logic [3:0] prot, input logic [1:0] mode,
                                   input logic write);
    if (prot == 4'b0000) return 1'b0;
    if (write) return (mode <= prot[1:0]);
    return (mode <= prot[3:2]) || (mode <= prot[1:0]);
  endfunction

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/acv_check_unit_if.sv
// Request, PTE-lookup, mode-register and response signals of the access-violation checker.
interface acv_check_unit_if #(
  parameter int unsigned VA_W      = 32,
  parameter int unsigned PAGE_BITS = 9,
  parameter int unsigned NCH       = 2
);
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned VPN_W = VA_W - PAGE_BITS;

  logic [NCH-1:0]      req_valid_h;
  logic [NCH*VA_W-1:0] req_va_h;
  logic [NCH*2-1:0]    req_size_h;
  logic [NCH-1:0]      req_write_h;
  logic [NCH-1:0]      req_mode_ovr_h;
  logic [NCH*2-1:0]    req_mode_h;
  logic [NCH-1:0]      req_ready_h;

  logic                pte_req_h;
  logic [VPN_W-1:0]    pte_vpn_h;
  logic                pte_ack_h;
  logic                pte_valid_h;
  logic [3:0]          pte_prot_h;

  logic                mode_wr_h;
  logic [1:0]          mode_d_h;
  logic                mme_wr_h;
  logic                mme_d_h;
  logic [1:0]          cur_mode_h;
  logic                mme_h;

  logic                rsp_valid_h;
  logic                rsp_ready_h;
  logic [CH_W-1:0]     rsp_ch_h;
  logic                rsp_acv_h;
  logic                rsp_tnv_h;
  logic                rsp_xpage_h;
  logic                rsp_fpage_h;

  // Requesters, PTE source and response consumer
  modport master (
    output req_valid_h, req_va_h, req_size_h, req_write_h, req_mode_ovr_h, req_mode_h,
    input  req_ready_h,
    input  pte_req_h, pte_vpn_h,
    output pte_ack_h, pte_valid_h, pte_prot_h,
    output mode_wr_h, mode_d_h, mme_wr_h, mme_d_h,
    input  cur_mode_h, mme_h,
    input  rsp_valid_h, rsp_ch_h, rsp_acv_h, rsp_tnv_h, rsp_xpage_h, rsp_fpage_h,
    output rsp_ready_h
  );

  // Checker side
  modport slave (
    input  req_valid_h, req_va_h, req_size_h, req_write_h, req_mode_ovr_h, req_mode_h,
    output req_ready_h,
    output pte_req_h, pte_vpn_h,
    input  pte_ack_h, pte_valid_h, pte_prot_h,
    input  mode_wr_h, mode_d_h, mme_wr_h, mme_d_h,
    output cur_mode_h, mme_h,
    output rsp_valid_h, rsp_ch_h, rsp_acv_h, rsp_tnv_h, rsp_xpage_h, rsp_fpage_h,
    input  rsp_ready_h
  );

endinterface

// File: rtl/acv_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module acv_rr_arb #(
  parameter  int unsigned NCH  = 2,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  output logic [NCH-1:0]  gnt_c,
  output logic [CH_W-1:0] gnt_idx_c
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] cand_c;
  logic            found_c;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found_c   = 1'b0;
    cand_c    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand_c = CH_W'((32'(ptr_q) + k) % NCH);
      if (!found_c && req[cand_c]) begin
        found_c        = 1'b1;
        gnt_c[cand_c]  = 1'b1;
        gnt_idx_c      = cand_c;
      end
    end
  end

  // Pointer moves to the channel just past the one granted
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found_c) begin
      ptr_d = (32'(gnt_idx_c) == NCH - 1) ? '0 : CH_W'(32'(gnt_idx_c) + 32'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/acv_check_unit.sv
// Multi-channel access-violation checker: arbitrates requests, fetches page protection
// over the PTE handshake (two lookups for page-crossing accesses), returns a registered result.
module acv_check_unit
  import acv_pkg::*;
#(
  parameter int unsigned VA_W      = 32,
  parameter int unsigned PAGE_BITS = 9,
  parameter int unsigned NCH       = 2
) (
  input logic              b_clk_h,
  input logic              init_h,
  acv_check_unit_if.slave  bus
);

  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned VPN_W  = VA_W - PAGE_BITS;
  localparam int unsigned SPAN_W = PAGE_BITS + 1;

  acv_state_e       state_q, state_d;

  logic [NCH-1:0]   gnt_c;
  logic [CH_W-1:0]  gnt_idx_c;
  logic             accept_c;

  logic [VA_W-1:0]  sel_va_c;
  logic [1:0]       sel_size_c;
  logic [1:0]       sel_mode_c;
  logic             sel_write_c;
  logic [SPAN_W-1:0] span_c;
  logic             sel_xpage_c;

  logic             ok_c;
  logic             fault_c;

  logic [CH_W-1:0]  lk_ch_q, lk_ch_d;
  logic [VPN_W-1:0] lk_vpn_q, lk_vpn_d;
  logic             lk_wr_q, lk_wr_d;
  logic [1:0]       lk_mode_q, lk_mode_d;
  logic             lk_xpage_q, lk_xpage_d;

  logic             pte_req_q, pte_req_d;
  logic [VPN_W-1:0] pte_vpn_q, pte_vpn_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0]  rsp_ch_q, rsp_ch_d;
  acv_flags_t       rsp_q, rsp_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic             mme_q, mme_d;

  // Accept is also blocked while reset is held so req_ready_h reads 0
  assign accept_c = (state_q == ST_IDLE) && !init_h && (|bus.req_valid_h);

  acv_rr_arb #(.NCH(NCH)) u_arb (
    .clk       (b_clk_h),
    .rst       (init_h),
    .req       (bus.req_valid_h),
    .advance   (accept_c),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c)
  );

  always_comb begin
    sel_va_c    = bus.req_va_h[32'(gnt_idx_c) * VA_W +: VA_W];
    sel_size_c  = bus.req_size_h[32'(gnt_idx_c) * 2 +: 2];
    sel_write_c = bus.req_write_h[gnt_idx_c];
    sel_mode_c  = bus.req_mode_ovr_h[gnt_idx_c] ? bus.req_mode_h[32'(gnt_idx_c) * 2 +: 2]
                                                : cur_mode_q;
    span_c      = SPAN_W'(sel_va_c[PAGE_BITS-1:0]) + SPAN_W'(bytes_of(sel_size_c))
                - SPAN_W'(1);
    sel_xpage_c = span_c[SPAN_W-1];
    ok_c        = prot_ok(bus.pte_prot_h, lk_mode_q, lk_wr_q);
    fault_c     = !ok_c || !bus.pte_valid_h;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = mme_q ? ST_LOOK1 : ST_RESP;
      ST_LOOK1: if (bus.pte_ack_h) state_d = (fault_c || !lk_xpage_q) ? ST_RESP : ST_LOOK2;
      ST_LOOK2: if (bus.pte_ack_h) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready_h) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    lk_ch_d    = lk_ch_q;
    lk_vpn_d   = lk_vpn_q;
    lk_wr_d    = lk_wr_q;
    lk_mode_d  = lk_mode_q;
    lk_xpage_d = lk_xpage_q;
    rsp_ch_d   = rsp_ch_q;
    rsp_d      = rsp_q;
    cur_mode_d = bus.mode_wr_h ? bus.mode_d_h : cur_mode_q;
    mme_d      = bus.mme_wr_h ? bus.mme_d_h : mme_q;

    if (accept_c) begin
      lk_ch_d    = gnt_idx_c;
      lk_vpn_d   = sel_va_c[VA_W-1:PAGE_BITS];
      lk_wr_d    = sel_write_c;
      lk_mode_d  = sel_mode_c;
      lk_xpage_d = sel_xpage_c;
      if (!mme_q) begin
        rsp_ch_d = gnt_idx_c;
        rsp_d    = '{acv: 1'b0, tnv: 1'b0, xpage: sel_xpage_c, fpage: 1'b0};
      end
    end

    if ((state_q == ST_LOOK1 || state_q == ST_LOOK2) && state_d == ST_RESP) begin
      rsp_ch_d = lk_ch_q;
      rsp_d    = '{acv: !ok_c, tnv: !bus.pte_valid_h, xpage: lk_xpage_q,
                   fpage: (state_q == ST_LOOK2) && fault_c};
    end

    pte_req_d = (state_d == ST_LOOK1) || (state_d == ST_LOOK2);
    pte_vpn_d = '0;
    if (state_d == ST_LOOK1)      pte_vpn_d = lk_vpn_d;
    else if (state_d == ST_LOOK2) pte_vpn_d = lk_vpn_q + VPN_W'(1);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge b_clk_h or posedge init_h) begin
    if (init_h) begin
      state_q     <= ST_IDLE;
      lk_ch_q     <= '0;
      lk_vpn_q    <= '0;
      lk_wr_q     <= 1'b0;
      lk_mode_q   <= '0;
      lk_xpage_q  <= 1'b0;
      pte_req_q   <= 1'b0;
      pte_vpn_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_q       <= '0;
      cur_mode_q  <= '0;
      mme_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lk_ch_q     <= lk_ch_d;
      lk_vpn_q    <= lk_vpn_d;
      lk_wr_q     <= lk_wr_d;
      lk_mode_q   <= lk_mode_d;
      lk_xpage_q  <= lk_xpage_d;
      pte_req_q   <= pte_req_d;
      pte_vpn_q   <= pte_vpn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_q       <= rsp_d;
      cur_mode_q  <= cur_mode_d;
      mme_q       <= mme_d;
    end
  end

  assign bus.req_ready_h = accept_c ? gnt_c : '0;
  assign bus.pte_req_h   = pte_req_q;
  assign bus.pte_vpn_h   = pte_vpn_q;
  assign bus.cur_mode_h  = cur_mode_q;
  assign bus.mme_h       = mme_q;
  assign bus.rsp_valid_h = rsp_valid_q;
  assign bus.rsp_ch_h    = rsp_ch_q;
  assign bus.rsp_acv_h   = rsp_q.acv;
  assign bus.rsp_tnv_h   = rsp_q.tnv;
  assign bus.rsp_xpage_h = rsp_q.xpage;
  assign bus.rsp_fpage_h = rsp_q.fpage;

endmodule

// File: tb/tb_acv_check_unit.sv
// Directed bench for acv_check_unit with hand-computed expectations.
module tb_acv_check_unit;
  import acv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  acv_check_unit_if #(.VA_W(32), .PAGE_BITS(9), .NCH(2)) bus ();

  acv_check_unit #(.VA_W(32), .PAGE_BITS(9), .NCH(2)) dut (
    .b_clk_h (clk),
    .init_h  (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int ch, input logic [31:0] va, input logic [1:0] size,
                           input logic wr, input logic ovr, input logic [1:0] md);
    bus.req_valid_h[ch]         = 1'b1;
    bus.req_va_h[ch*32 +: 32]   = va;
    bus.req_size_h[ch*2 +: 2]   = size;
    bus.req_write_h[ch]         = wr;
    bus.req_mode_ovr_h[ch]      = ovr;
    bus.req_mode_h[ch*2 +: 2]   = md;
  endtask

  task automatic accept(input string tag, input logic [1:0] exp_rdy);
    #1;
    chk(tag, 32'(bus.req_ready_h), 32'(exp_rdy));
    @(posedge clk);
    #1;
    bus.req_valid_h = '0;
  endtask

  task automatic pte_ack(input logic valid, input logic [3:0] prot);
    bus.pte_ack_h   = 1'b1;
    bus.pte_valid_h = valid;
    bus.pte_prot_h  = prot;
    tick();
    bus.pte_ack_h   = 1'b0;
  endtask

  task automatic release_rsp();
    bus.rsp_ready_h = 1'b1;
    tick();
    bus.rsp_ready_h = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid_h), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] ch, input logic acv,
                           input logic tnv, input logic xp, input logic fp);
    chk({tag, "_valid"}, 32'(bus.rsp_valid_h), 32'd1);
    chk({tag, "_ch"},    32'(bus.rsp_ch_h),    32'(ch));
    chk({tag, "_acv"},   32'(bus.rsp_acv_h),   32'(acv));
    chk({tag, "_tnv"},   32'(bus.rsp_tnv_h),   32'(tnv));
    chk({tag, "_xpage"}, 32'(bus.rsp_xpage_h), 32'(xp));
    chk({tag, "_fpage"}, 32'(bus.rsp_fpage_h), 32'(fp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_h = '0; bus.req_va_h = '0; bus.req_size_h = '0; bus.req_write_h = '0;
    bus.req_mode_ovr_h = '0; bus.req_mode_h = '0;
    bus.pte_ack_h = 1'b0; bus.pte_valid_h = 1'b0; bus.pte_prot_h = '0;
    bus.mode_wr_h = 1'b0; bus.mode_d_h = '0; bus.mme_wr_h = 1'b0; bus.mme_d_h = 1'b0;
    bus.rsp_ready_h = 1'b0;

    repeat (2) tick();
    chk("rst_pte_req",  32'(bus.pte_req_h),   32'd0);
    chk("rst_rsp_vld",  32'(bus.rsp_valid_h), 32'd0);
    chk("rst_ready",    32'(bus.req_ready_h), 32'd0);
    chk("rst_mode",     32'(bus.cur_mode_h),  32'd0);
    chk("rst_mme",      32'(bus.mme_h),       32'd0);
    rst = 1'b0;
    tick();

    // mme off: long read at 0x1FE spans 0x1FE..0x201
    drive_req(0, 32'h1FE, SIZE_LONG, 1'b0, 1'b0, 2'd0);
    accept("t1_ready", 2'b01);
    chk("t1_pte_req", 32'(bus.pte_req_h), 32'd0);
    check_rsp("t1", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    release_rsp();

    bus.mme_wr_h = 1'b1; bus.mme_d_h = 1'b1; bus.mode_wr_h = 1'b1; bus.mode_d_h = MODE_USER;
    tick();
    bus.mme_wr_h = 1'b0; bus.mode_wr_h = 1'b0;
    chk("mme_set",  32'(bus.mme_h),      32'd1);
    chk("mode_set", 32'(bus.cur_mode_h), 32'd3);

    // User write, WL = 3: allowed, single lookup of vpn 8
    drive_req(0, 32'h1000, SIZE_LONG, 1'b1, 1'b0, 2'd0);
    accept("t2_ready", 2'b01);
    chk("t2_pte_req", 32'(bus.pte_req_h),   32'd1);
    chk("t2_pte_vpn", 32'(bus.pte_vpn_h),   32'h8);
    chk("t2_early",   32'(bus.rsp_valid_h), 32'd0);
    pte_ack(1'b1, 4'b0111);
    chk("t2_pte_drop", 32'(bus.pte_req_h), 32'd0);
    check_rsp("t2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_rsp();

    // User read, RL = WL = 1: violation; ack arrives one cycle late
    drive_req(0, 32'h1000, SIZE_LONG, 1'b0, 1'b0, 2'd0);
    accept("t3_ready", 2'b01);
    tick();
    chk("t3_pte_hold", 32'(bus.pte_req_h),   32'd1);
    chk("t3_wait",     32'(bus.rsp_valid_h), 32'd0);
    pte_ack(1'b1, 4'b0101);
    check_rsp("t3", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    release_rsp();

    // Kernel override, cross-page word, invalid PTE: stops after first page
    drive_req(0, 32'h1FF, SIZE_WORD, 1'b0, 1'b1, MODE_KERNEL);
    accept("t4_ready", 2'b01);
    chk("t4_pte_vpn", 32'(bus.pte_vpn_h), 32'h0);
    pte_ack(1'b0, 4'b0001);
    chk("t4_pte_drop", 32'(bus.pte_req_h), 32'd0);
    check_rsp("t4", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    release_rsp();

    // Mode write coincident with accept: old mode (user) is checked
    drive_req(0, 32'h2000, SIZE_BYTE, 1'b0, 1'b0, 2'd0);
    bus.mode_wr_h = 1'b1; bus.mode_d_h = MODE_KERNEL;
    accept("t5_ready", 2'b01);
    bus.mode_wr_h = 1'b0;
    chk("t5_new_mode", 32'(bus.cur_mode_h), 32'd0);
    chk("t5_pte_vpn",  32'(bus.pte_vpn_h),  32'h10);
    pte_ack(1'b1, 4'b0100);
    check_rsp("t5", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    release_rsp();
    bus.mode_wr_h = 1'b1; bus.mode_d_h = MODE_USER;
    tick();
    bus.mode_wr_h = 1'b0;

    // Quad write at 0x3FC: vpn 1 allowed, vpn 2 denies all
    drive_req(1, 32'h3FC, SIZE_QUAD, 1'b1, 1'b0, 2'd0);
    accept("t6_ready", 2'b10);
    chk("t6_vpn1", 32'(bus.pte_vpn_h), 32'h1);
    pte_ack(1'b1, 4'b0111);
    chk("t6_pte_req2", 32'(bus.pte_req_h),   32'd1);
    chk("t6_vpn2",     32'(bus.pte_vpn_h),   32'h2);
    chk("t6_wait",     32'(bus.rsp_valid_h), 32'd0);
    pte_ack(1'b1, 4'b0000);
    check_rsp("t6", 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    release_rsp();

    // Round robin with both channels held valid (pointer is back at 0)
    bus.mme_wr_h = 1'b1; bus.mme_d_h = 1'b0;
    tick();
    bus.mme_wr_h = 1'b0;
    drive_req(0, 32'h0,   SIZE_BYTE, 1'b0, 1'b0, 2'd0);
    drive_req(1, 32'h200, SIZE_BYTE, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready_h), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr_ch", 32'(bus.rsp_ch_h), 32'(i % 2));
      bus.rsp_ready_h = 1'b1;
      tick();
      bus.rsp_ready_h = 1'b0;
    end
    bus.req_valid_h = '0;

    // Stalled response stays stable and blocks new accepts
    drive_req(1, 32'h1FF, SIZE_WORD, 1'b0, 1'b0, 2'd0);
    accept("st_ready", 2'b10);
    bus.req_valid_h[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_rsp("stall", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stall_ready", 32'(bus.req_ready_h), 32'd0);
      @(posedge clk);
    end
    #1;
    bus.req_valid_h = '0;
    release_rsp();

    // Reset in LOOK2, then a late ack must be ignored
    bus.mme_wr_h = 1'b1; bus.mme_d_h = 1'b1;
    tick();
    bus.mme_wr_h = 1'b0;
    drive_req(0, 32'h3FC, SIZE_QUAD, 1'b0, 1'b0, 2'd0);
    accept("r_ready", 2'b01);
    pte_ack(1'b1, 4'b0111);
    chk("r_look2_req", 32'(bus.pte_req_h), 32'd1);
    chk("r_look2_vpn", 32'(bus.pte_vpn_h), 32'h2);
    rst = 1'b1;
    #1;
    chk("r_pte_req", 32'(bus.pte_req_h),   32'd0);
    chk("r_pte_vpn", 32'(bus.pte_vpn_h),   32'd0);
    chk("r_rsp_vld", 32'(bus.rsp_valid_h), 32'd0);
    chk("r_ready0",  32'(bus.req_ready_h), 32'd0);
    chk("r_mme",     32'(bus.mme_h),       32'd0);
    chk("r_mode",    32'(bus.cur_mode_h),  32'd0);
    tick();
    rst = 1'b0;
    pte_ack(1'b1, 4'b0000);
    chk("late_rsp", 32'(bus.rsp_valid_h), 32'd0);
    chk("late_pte", 32'(bus.pte_req_h),   32'd0);
    tick();
    chk("late_rsp2", 32'(bus.rsp_valid_h), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
